// File: rtl/joy_serial_scanner.sv
// Scans a daisy-chained 74HC165-style chain of NCHAN controllers and publishes a
// frame-coherent, active-high button bus, optionally filtered by two-frame agreement.
`timescale 1ns/1ps
module joy_serial_scanner #(
  parameter int NCHAN  = 2,
  parameter int NBITS  = 12,
  parameter int CLKDIV = 4,
  parameter int FILTER = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   joy_data,
  output logic                   joy_clk,
  output logic                   joy_load_n,
  output logic [NCHAN*NBITS-1:0] joy_state,
  output logic                   frame_done,
  output logic                   state_changed
);
  localparam int TOTAL = NCHAN * NBITS;
  localparam int BW    = $clog2(TOTAL + 1);
  localparam int DW    = $clog2(CLKDIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL - 1);

  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, DONE} state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [TOTAL-1:0] shreg_q, shreg_d;
  logic [TOTAL-1:0] hist_q, hist_d;
  logic [TOTAL-1:0] joy_state_q, joy_state_d;
  logic             joy_clk_q, joy_clk_d;
  logic             joy_load_n_q, joy_load_n_d;
  logic             frame_done_q, frame_done_d;
  logic             state_changed_q, state_changed_d;
  logic             tick;
  logic             accept;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    accept  = 1'b0;

    case (state_q)
      IDLE: if (tick && enable) state_d = LOAD;
      LOAD: if (tick) begin
        state_d = LOW;
        bit_d   = '0;
      end
      LOW: if (tick) begin
        for (int i = 0; i < TOTAL; i++) begin
          if (bit_q == BW'(i)) shreg_d[i] = ~joy_data;
        end
        state_d = HIGH;
      end
      HIGH: if (tick) begin
        bit_d   = bit_q + 1'b1;
        state_d = (bit_q == BIT_LAST) ? DONE : LOW;
      end
      DONE: begin
        div_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The frame is complete on the transition into DONE, so results appear during DONE.
    if (FILTER != 0) accept = (shreg_q == hist_q) && (shreg_q != joy_state_q);
    else             accept = (shreg_q != joy_state_q);

    frame_done_d    = (state_d == DONE);
    state_changed_d = frame_done_d && accept;
    joy_state_d     = state_changed_d ? shreg_q : joy_state_q;
    hist_d          = frame_done_d ? shreg_q : hist_q;
    joy_clk_d       = (state_d == HIGH);
    joy_load_n_d    = (state_d != LOAD);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      div_q           <= '0;
      bit_q           <= '0;
      hist_q          <= '0;
      joy_state_q     <= '0;
      joy_clk_q       <= 1'b0;
      joy_load_n_q    <= 1'b1;
      frame_done_q    <= 1'b0;
      state_changed_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      div_q           <= div_d;
      bit_q           <= bit_d;
      hist_q          <= hist_d;
      joy_state_q     <= joy_state_d;
      joy_clk_q       <= joy_clk_d;
      joy_load_n_q    <= joy_load_n_d;
      frame_done_q    <= frame_done_d;
      state_changed_q <= state_changed_d;
    end
  end

  // NOTE: the capture register needs no reset; every bit is rewritten before a frame completes.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign joy_clk       = joy_clk_q;
  assign joy_load_n    = joy_load_n_q;
  assign joy_state     = joy_state_q;
  assign frame_done    = frame_done_q;
  assign state_changed = state_changed_q;
endmodule
